// File: rtl/cube_game_scorer.sv
// cube_game_scorer: streaming "Game N: a red, b green; c blue\n" scorer producing feasible-ID and power sums.
// Define CUBE_GAME_SCORER_PARSE_CHECK_EN to flag malformed input on parse_error.
module cube_game_scorer #(
  parameter int COUNT_W     = 8,
  parameter int ID_W        = 16,
  parameter int RESULT_W    = 64,
  parameter int LIMIT_RED   = 12,
  parameter int LIMIT_GREEN = 13,
  parameter int LIMIT_BLUE  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                input_valid,
  input  logic [7:0]          char_in,
  input  logic                input_last,
  output logic                input_ready,
  output logic [RESULT_W-1:0] result_possible,
  output logic [RESULT_W-1:0] result_power,
  output logic                output_valid,
  output logic                parse_error
);
  localparam logic [3:0] IDLE = 4'd0, GAME_ID = 4'd1, PRE_NUM = 4'd2, NUM = 4'd3, COLOR = 4'd4,
                         POST_COL = 4'd5, MUL1 = 4'd6, MUL2 = 4'd7, DONE = 4'd8;
`ifdef CUBE_GAME_SCORER_PARSE_CHECK_EN
  localparam logic CHECK = 1'b1;
`else
  localparam logic CHECK = 1'b0;
`endif
  localparam logic [COUNT_W-1:0] LIM_R = COUNT_W'(LIMIT_RED);
  localparam logic [COUNT_W-1:0] LIM_G = COUNT_W'(LIMIT_GREEN);
  localparam logic [COUNT_W-1:0] LIM_B = COUNT_W'(LIMIT_BLUE);
  logic [3:0]             state, nxt;
  logic [ID_W-1:0]        id, id_sat;
  logic [COUNT_W-1:0]     cnt, cnt_sat, max_r, max_g, max_b;
  logic [2*COUNT_W-1:0]   prod;
  logic [3*COUNT_W-1:0]   power;
  logic [COUNT_W+3:0]     cnt_x;
  logic [ID_W+3:0]        id_x;
  logic                   bad, last_pend, err, acc, dig;
  assign input_ready  = state != MUL1 && state != MUL2 && state != DONE;
  assign output_valid = state == DONE;
  assign acc   = input_valid && input_ready;
  assign dig   = char_in >= "0" && char_in <= "9";
  // decimal accumulate with clamp to all-ones; the extra 4 bits catch overflow
  assign cnt_x   = {4'd0, cnt} * (COUNT_W+4)'(10) + (COUNT_W+4)'(char_in[3:0]);
  assign id_x    = {4'd0, id} * (ID_W+4)'(10) + (ID_W+4)'(char_in[3:0]);
  assign cnt_sat = |cnt_x[COUNT_W+3:COUNT_W] ? '1 : cnt_x[COUNT_W-1:0];
  assign id_sat  = |id_x[ID_W+3:ID_W] ? '1 : id_x[ID_W-1:0];
  assign power   = (3*COUNT_W)'(prod) * (3*COUNT_W)'(max_b);
  always_comb begin
    nxt = state;
    err = 1'b0;
    if (state == MUL1) nxt = MUL2;
    else if (state == MUL2) nxt = last_pend ? DONE : IDLE;
    else if (acc && input_last) begin
      nxt = state == POST_COL ? MUL1 : DONE;
      err = state != POST_COL && state != IDLE;
    end else if (acc) begin
      case (state)
        IDLE:     nxt = char_in == " " ? GAME_ID : IDLE;
        GAME_ID:  begin nxt = char_in == ":" ? PRE_NUM : GAME_ID; err = !dig && char_in != ":"; end
        PRE_NUM:  begin nxt = char_in == " " ? NUM : PRE_NUM; err = char_in != " "; end
        NUM:      begin nxt = char_in == " " ? COLOR : NUM; err = !dig && char_in != " "; end
        COLOR:    begin
          nxt = (char_in == "r" || char_in == "g" || char_in == "b") ? POST_COL : COLOR;
          err = nxt == COLOR;
        end
        POST_COL: nxt = (char_in == "," || char_in == ";") ? PRE_NUM : char_in == "\n" ? MUL1 : POST_COL;
        default:  nxt = state;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      id              <= '0;
      cnt             <= '0;
      max_r           <= '0;
      max_g           <= '0;
      max_b           <= '0;
      prod            <= '0;
      bad             <= 1'b0;
      last_pend       <= 1'b0;
      parse_error     <= 1'b0;
      result_possible <= '0;
      result_power    <= '0;
    end else begin
      state       <= nxt;
      parse_error <= parse_error | (err & CHECK);
      if (acc && input_last && state == POST_COL) last_pend <= 1'b1;
      if (acc && !input_last) begin
        case (state)
          IDLE:    if (char_in == " ") begin
            id    <= '0;
            max_r <= '0;
            max_g <= '0;
            max_b <= '0;
            bad   <= 1'b0;
          end
          GAME_ID: if (dig) id <= id_sat;
          PRE_NUM: if (char_in == " ") cnt <= '0;
          NUM:     if (dig) cnt <= cnt_sat;
          COLOR:   if (char_in == "r") begin
            max_r <= cnt > max_r ? cnt : max_r;
            bad   <= bad | (cnt > LIM_R);
          end else if (char_in == "g") begin
            max_g <= cnt > max_g ? cnt : max_g;
            bad   <= bad | (cnt > LIM_G);
          end else if (char_in == "b") begin
            max_b <= cnt > max_b ? cnt : max_b;
            bad   <= bad | (cnt > LIM_B);
          end
          default: ;
        endcase
      end
      if (state == MUL1) prod <= (2*COUNT_W)'(max_r) * (2*COUNT_W)'(max_g);
      if (state == MUL2) begin
        result_power <= result_power + RESULT_W'(power);
        if (!bad) result_possible <= result_possible + RESULT_W'(id);
      end
    end
  end
endmodule

// File: tb/tb_cube_game_scorer.sv
// tb_cube_game_scorer: directed and randomized streams checked against a per-game reference model.
module tb_cube_game_scorer;
`ifdef CUBE_GAME_SCORER_PARSE_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, input_valid = 1'b0, input_last = 1'b0;
  logic [7:0]  char_in = 8'd0;
  logic        input_ready, output_valid, parse_error;
  logic [63:0] result_possible, result_power;
  int          vectors = 0, miscompares = 0;
  bit          gaps = 1'b1;
  cube_game_scorer dut (
    .clk(clk), .rst_n(rst_n), .input_valid(input_valid), .char_in(char_in), .input_last(input_last),
    .input_ready(input_ready), .result_possible(result_possible), .result_power(result_power),
    .output_valid(output_valid), .parse_error(parse_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    input_valid = 1'b0;
    input_last  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  // called and returns at a negedge; returns right after the character is accepted
  task automatic send(input logic [7:0] c, input logic last);
    int n = 0;
    if (gaps) begin
      input_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    input_valid = 1'b1;
    char_in     = c;
    input_last  = last;
    while (!input_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask
  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && i == s.len() - 1);
    input_valid = 1'b0;
    input_last  = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!output_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(output_valid), 64'd1);
  endtask
  // reference: per game, maxima of clamped counts, feasibility on raw counts
  task automatic add_game(inout string s, inout logic [63:0] ep, inout logic [63:0] ew);
    string names[3] = '{"red", "green", "blue"};
    int    lim[3]   = '{12, 13, 14};
    int    mx[3]    = '{0, 0, 0};
    int    id = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60000, 70000)) : int'($urandom_range(1, 999));
    int    nd = $urandom_range(1, 3);
    bit    ok = 1'b1;
    s = {s, $sformatf("Game %0d:", id)};
    for (int d = 0; d < nd; d++) begin
      int k  = $urandom_range(1, 3);
      int c0 = $urandom_range(0, 2);
      if (d > 0) s = {s, ";"};
      for (int j = 0; j < k; j++) begin
        int c = (c0 + j) % 3;
        int v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 400)) : int'($urandom_range(0, 20));
        if (j > 0) s = {s, ","};
        s = {s, $sformatf(" %0d %s", v, names[c])};
        mx[c] = mx[c] > (v > 255 ? 255 : v) ? mx[c] : (v > 255 ? 255 : v);
        if (v > lim[c]) ok = 1'b0;
      end
    end
    s = {s, "\n"};
    if (ok) ep += 64'(id > 65535 ? 65535 : id);
    ew += 64'(mx[0]) * 64'(mx[1]) * 64'(mx[2]);
  endtask
  string g1 = "Game 1: 3 blue, 4 red; 1 red, 2 green, 6 blue; 2 green\n";
  string g3 = "Game 3: 8 green, 6 blue, 20 red; 5 blue, 4 red, 13 green; 5 green, 1 red\n";
  string five = {g1, "Game 2: 1 blue, 2 green; 3 green, 4 blue, 1 red; 1 green, 1 blue\n", g3,
                 "Game 4: 1 green, 3 red, 6 blue; 3 green, 6 red; 3 green, 15 blue, 14 red\n",
                 "Game 5: 6 red, 1 blue, 3 green; 2 blue, 1 red, 2 green\n"};
  initial begin
    do_reset();
    check("rst_ready", 64'(input_ready), 64'd1);
    check("rst_possible", result_possible, 64'd0);
    check("rst_power", result_power, 64'd0);
    check("rst_valid", 64'(output_valid), 64'd0);
    check("rst_error", 64'(parse_error), 64'd0);
    // five-game example, gapped and then continuous input
    for (int m = 0; m < 2; m++) begin
      gaps = (m == 0);
      do_reset();
      send_str(five, 1'b1);
      check("five_valid_t1", 64'(output_valid), 64'd0);
      @(negedge clk);
      check("five_valid_t2", 64'(output_valid), 64'd0);
      @(negedge clk);
      check("five_valid_t3", 64'(output_valid), 64'd1);
      check("five_possible", result_possible, 64'd8);
      check("five_power", result_power, 64'd2286);
      check("five_error", 64'(parse_error), 64'd0);
    end
    // single game: two-cycle stall, then a last character in IDLE
    gaps = 1'b0;
    do_reset();
    send_str(g3, 1'b0);
    check("g3_ready_t1", 64'(input_ready), 64'd0);
    @(negedge clk);
    check("g3_ready_t2", 64'(input_ready), 64'd0);
    check("g3_power_hold", result_power, 64'd0);
    @(negedge clk);
    check("g3_ready_t3", 64'(input_ready), 64'd1);
    check("g3_possible", result_possible, 64'd0);
    check("g3_power", result_power, 64'd1560);
    send_str("G", 1'b1);
    check("idle_last_valid", 64'(output_valid), 64'd1);
    check("idle_last_power", result_power, 64'd1560);
    // saturating count, last on a colour-word character
    do_reset();
    send_str("Game 7: 300 red, 2 green, 1 blue", 1'b1);
    wait_done();
    check("sat_possible", result_possible, 64'd0);
    check("sat_power", result_power, 64'd510);
    // bad colour letter: parsing stalls in COLOR until a valid letter
    do_reset();
    send_str("Game 2: 1 xed, 1 green", 1'b1);
    wait_done();
    check("badcol_error", 64'(parse_error), 64'(PCHK));
    check("badcol_possible", result_possible, 64'd2);
    check("badcol_power", result_power, 64'd0);
    // last inside a number discards the game
    do_reset();
    send_str("Game 4: 12", 1'b1);
    check("abort_valid", 64'(output_valid), 64'd1);
    check("abort_error", 64'(parse_error), 64'(PCHK));
    check("abort_possible", result_possible, 64'd0);
    // reset during MUL2, then replay
    do_reset();
    send_str(g1, 1'b0);
    @(negedge clk);
    check("mul2_ready", 64'(input_ready), 64'd0);
    do_reset();
    check("abort_rst_power", result_power, 64'd0);
    check("abort_rst_possible", result_possible, 64'd0);
    send_str(g1, 1'b1);
    wait_done();
    check("replay_possible", result_possible, 64'd1);
    check("replay_power", result_power, 64'd48);
    // randomized multi-game streams
    for (int r = 0; r < 12; r++) begin
      string s = "";
      logic [63:0] ep = 64'd0, ew = 64'd0;
      int ng = $urandom_range(1, 4);
      for (int g = 0; g < ng; g++) add_game(s, ep, ew);
      gaps = r[0];
      do_reset();
      send_str(s, 1'b1);
      wait_done();
      check($sformatf("rand%0d_possible", r), result_possible, ep);
      check($sformatf("rand%0d_power", r), result_power, ew);
      check($sformatf("rand%0d_error", r), 64'(parse_error), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
